// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi: NCH independent PS/2 device-side transmitters.
// Each channel has its own byte FIFO and frame FSM. All channels share one
// PS/2 clock divider, so frames on different channels run in lockstep.
module ps2_tx_multi #(
  parameter int NCH       = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 100
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [NCH-1:0]               wr,
  input  logic [8*NCH-1:0]             wr_data,
  input  logic [NCH-1:0]               inhibit,
  input  logic [NCH-1:0]               ovf_clr,
  output logic [NCH-1:0]               ps2_clk,
  output logic [NCH-1:0]               ps2_data,
  output logic [NCH-1:0]               full,
  output logic [(FIFO_BITS+1)*NCH-1:0] level,
  output logic [NCH-1:0]               overflow,
  output logic [NCH-1:0]               busy
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int CW    = $clog2(PS2DIV + 2);
  localparam logic [CW-1:0]        CNT_MAX = CW'(PS2DIV);
  localparam logic [FIFO_BITS:0]   DEPTH_L = {1'b1, {FIFO_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // ---------------- shared divider ----------------
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          clk_ph_q, clk_ph_d;
  logic          tick;

  // Divider next-state: count 0..PS2DIV, toggle the clock phase on wrap.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    clk_ph_d  = clk_ph_q;
    if (div_cnt_q == CNT_MAX) begin
      div_cnt_d = '0;
      clk_ph_d  = ~clk_ph_q;
    end
  end

  // Divider registers; phase starts high so idle lines read 1 out of reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_cnt_q <= '0;
      clk_ph_q  <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      clk_ph_q  <= clk_ph_d;
    end
  end

  // tick lands on the same edge where the phase goes 0 -> 1.
  assign tick = (div_cnt_q == CNT_MAX) && !clk_ph_q;

  // ---------------- per-channel logic ----------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t               state_q, state_d;
    logic [7:0]           sh_q, sh_d;
    logic [2:0]           bit_q, bit_d;
    logic                 par_q, par_d;
    logic                 data_q, data_d;
    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [FIFO_BITS:0]   lvl_q, lvl_d;
    logic                 ovf_q, ovf_d;
    logic                 full_w, push, pop, start, abort;

    assign full_w = (lvl_q == DEPTH_L);
    // Abort only before the stop bit; a stop bit in progress is allowed to finish.
    assign abort  = inhibit[gi] &&
                    (state_q == S_START || state_q == S_DATA || state_q == S_PARITY);
    assign start  = tick && (state_q == S_IDLE) && (lvl_q != '0) && !inhibit[gi];
    assign pop    = tick && (state_q == S_STOP) && !abort;
    // A pop in the same cycle frees a slot, so a write on a full FIFO still lands.
    assign push   = wr[gi] && (!full_w || pop);

    // State register plus frame and FIFO bookkeeping registers.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        state_q <= S_IDLE;
        sh_q    <= '0;
        bit_q   <= '0;
        par_q   <= 1'b0;
        data_q  <= 1'b1;
        wp_q    <= '0;
        rp_q    <= '0;
        lvl_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        sh_q    <= sh_d;
        bit_q   <= bit_d;
        par_q   <= par_d;
        data_q  <= data_d;
        wp_q    <= wp_d;
        rp_q    <= rp_d;
        lvl_q   <= lvl_d;
        ovf_q   <= ovf_d;
      end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk_sys) begin
      if (push) mem_q[wp_q] <= wr_data[8*gi +: 8];
    end

    // Next-state logic: frame steps on tick, inhibit aborts immediately.
    always_comb begin
      state_d = state_q;
      if (abort) begin
        state_d = S_IDLE;
      end else if (tick) begin
        case (state_q)
          S_IDLE:   if (start) state_d = S_START;
          S_START:  state_d = S_DATA;
          S_DATA:   if (bit_q == 3'd7) state_d = S_PARITY;
          S_PARITY: state_d = S_STOP;
          S_STOP:   state_d = S_IDLE;
          default:  state_d = S_IDLE;
        endcase
      end
    end

    // Output/datapath logic: serial bit, shifter, parity, FIFO pointers.
    always_comb begin
      data_d = data_q;
      sh_d   = sh_q;
      bit_d  = bit_q;
      par_d  = par_q;
      if (abort) begin
        data_d = 1'b1;
      end else if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              // Head byte is copied, not popped, so an abort can resend it.
              sh_d   = mem_q[rp_q];
              par_d  = 1'b1;
              bit_d  = '0;
              data_d = 1'b0;
            end
          end
          S_START: begin
            data_d = sh_q[0];
            par_d  = par_q ^ sh_q[0];
            sh_d   = sh_q >> 1;
          end
          S_DATA: begin
            if (bit_q == 3'd7) begin
              data_d = par_q;
            end else begin
              data_d = sh_q[0];
              par_d  = par_q ^ sh_q[0];
              sh_d   = sh_q >> 1;
              bit_d  = bit_q + 3'd1;
            end
          end
          default: data_d = 1'b1;
        endcase
      end

      wp_d  = push ? wp_q + 1'b1 : wp_q;
      rp_d  = pop  ? rp_q + 1'b1 : rp_q;
      lvl_d = lvl_q;
      if (push && !pop) lvl_d = lvl_q + 1'b1;
      if (pop && !push) lvl_d = lvl_q - 1'b1;

      // A dropped write wins over a simultaneous clear.
      ovf_d = ovf_q;
      if (wr[gi] && !push) ovf_d = 1'b1;
      else if (ovf_clr[gi]) ovf_d = 1'b0;
    end

    assign ps2_clk[gi]                          = clk_ph_q | (state_q == S_IDLE);
    assign ps2_data[gi]                         = data_q;
    assign full[gi]                             = full_w;
    assign level[gi*(FIFO_BITS+1) +: FIFO_BITS+1] = lvl_q;
    assign overflow[gi]                         = ovf_q;
    assign busy[gi]                             = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// tb_ps2_tx_multi: directed bench for ps2_tx_multi with PS2DIV=2, 2 channels, depth 8.
module tb_ps2_tx_multi;
  localparam int NCH = 2;
  localparam int FB  = 3;
  localparam int DIV = 2;

  logic                    clk_sys = 1'b0;
  logic                    reset;
  logic [NCH-1:0]          wr;
  logic [8*NCH-1:0]        wr_data;
  logic [NCH-1:0]          inhibit;
  logic [NCH-1:0]          ovf_clr;
  logic [NCH-1:0]          ps2_clk;
  logic [NCH-1:0]          ps2_data;
  logic [NCH-1:0]          full;
  logic [(FB+1)*NCH-1:0]   level;
  logic [NCH-1:0]          overflow;
  logic [NCH-1:0]          busy;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_tx_multi #(.NCH(NCH), .FIFO_BITS(FB), .PS2DIV(DIV)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .wr       (wr),
    .wr_data  (wr_data),
    .inhibit  (inhibit),
    .ovf_clr  (ovf_clr),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .full     (full),
    .level    (level),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [3:0] lvl(input int ch);
    return level[ch*(FB+1) +: FB+1];
  endfunction

  // start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic write_byte(input int ch, input logic [7:0] b);
    wr[ch] = 1'b1;
    wr_data[8*ch +: 8] = b;
    step();
    wr[ch] = 1'b0;
  endtask

  // Step until ps2_clk of the channel goes low and back high.
  task automatic wait_rise(input int ch, output int cyc);
    cyc = 0;
    while (ps2_clk[ch] === 1'b1 && cyc < 40) begin step(); cyc++; end
    while (ps2_clk[ch] !== 1'b1 && cyc < 40) begin step(); cyc++; end
  endtask

  // Wait for a frame to start, then sample data at each clock rise.
  task automatic capture_frame(input int ch, output logic [10:0] bits, output int period);
    int cyc;
    int c;
    bits = '0;
    period = 0;
    cyc = 0;
    while (busy[ch] !== 1'b1 && cyc < 400) begin step(); cyc++; end
    check_eq($sformatf("ch%0d_frame_start", ch), busy[ch], 1);
    bits[0] = ps2_data[ch];
    for (int b = 1; b < 11; b++) begin
      wait_rise(ch, c);
      if (b == 1) period = c;
      bits[b] = ps2_data[ch];
    end
    $display("[TB] ch%0d frame %03h", ch, bits);
  endtask

  initial begin
    logic [10:0] f0, f1;
    int p0, p1, c;
    logic ok;

    reset = 1'b1; wr = '0; wr_data = '0; inhibit = '0; ovf_clr = '0;
    repeat (3) step();
    check_eq("rst_clk",  ps2_clk, 2'b11);
    check_eq("rst_data", ps2_data, 2'b11);
    check_eq("rst_level", level, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_ovf",  overflow, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;

    // ---- single byte 0x1C on ch0 ----
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (ps2_clk[0] !== 1'b1) ok = 1'b0; end
    check_eq("idle_clk_high_before", ok, 1);
    write_byte(0, 8'h1C);
    check_eq("lvl_after_write", lvl(0), 1);
    capture_frame(0, f0, p0);
    check_eq("frame_1c", f0, 11'h438);
    check_eq("bit_period", p0, 6);
    check_eq("lvl_at_stop", lvl(0), 1);
    wait_rise(0, c);
    check_eq("pop_cycles", c, 6);
    check_eq("lvl_after_stop", lvl(0), 0);
    check_eq("busy_after_stop", busy[0], 0);
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin step(); if (ps2_clk[0] !== 1'b1 || ps2_data[0] !== 1'b1) ok = 1'b0; end
    check_eq("idle_lines_high_after", ok, 1);

    // ---- lockstep on both channels ----
    wr = 2'b11; wr_data = {8'h01, 8'hAA};
    step();
    wr = '0;
    fork
      capture_frame(0, f0, p0);
      capture_frame(1, f1, p1);
    join
    check_eq("frame_aa_ch0", f0, frame_of(8'hAA));
    check_eq("frame_01_ch1", f1, frame_of(8'h01));
    check_eq("parity_ch0", f0[9], 1);
    check_eq("parity_ch1", f1[9], 0);
    check_eq("lockstep_busy", busy, 2'b11);
    wait_rise(0, c);
    check_eq("lvl_both_empty", level, 0);

    // ---- overflow with inhibit held, then pop-tick write on a full FIFO ----
    inhibit[0] = 1'b1;
    for (int i = 0; i < 9; i++) write_byte(0, 8'h10 + 8'(i));
    repeat (20) step();
    check_eq("ovf_level", lvl(0), 8);
    check_eq("ovf_full", full[0], 1);
    check_eq("ovf_flag", overflow[0], 1);
    check_eq("ovf_no_start", busy[0], 0);
    ovf_clr[0] = 1'b1; step(); ovf_clr[0] = 1'b0;
    check_eq("ovf_cleared", overflow[0], 0);
    inhibit[0] = 1'b0;
    capture_frame(0, f0, p0);
    check_eq("fifo_frame0", f0, frame_of(8'h10));
    repeat (5) step();
    wr[0] = 1'b1; wr_data[7:0] = 8'h99;
    step();
    wr[0] = 1'b0;
    check_eq("popwr_level", lvl(0), 8);
    check_eq("popwr_full", full[0], 1);
    check_eq("popwr_ovf", overflow[0], 0);
    for (int k = 1; k < 9; k++) begin
      capture_frame(0, f0, p0);
      check_eq($sformatf("fifo_frame%0d", k), f0, frame_of(k == 8 ? 8'h99 : 8'h10 + 8'(k)));
      wait_rise(0, c);
    end
    check_eq("fifo_drained", lvl(0), 0);
    ok = 1'b1;
    for (int i = 0; i < 80; i++) begin step(); if (busy[0] !== 1'b0) ok = 1'b0; end
    check_eq("ninth_byte_absent", ok, 1);

    // ---- inhibit abort during D3 and retransmit ----
    write_byte(0, 8'h5A);
    c = 0;
    while (busy[0] !== 1'b1 && c < 100) begin step(); c++; end
    for (int i = 0; i < 4; i++) wait_rise(0, c);
    step();
    check_eq("pre_abort_busy", busy[0], 1);
    inhibit[0] = 1'b1;
    step();
    check_eq("abort_data", ps2_data[0], 1);
    check_eq("abort_clk", ps2_clk[0], 1);
    check_eq("abort_busy", busy[0], 0);
    check_eq("abort_level", lvl(0), 1);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin step(); if (busy[0] !== 1'b0 || ps2_clk[0] !== 1'b1) ok = 1'b0; end
    check_eq("inhibit_holds_idle", ok, 1);
    inhibit[0] = 1'b0;
    capture_frame(0, f0, p0);
    check_eq("retransmit_5a", f0, frame_of(8'h5A));
    wait_rise(0, c);
    check_eq("retransmit_level", lvl(0), 0);

    // ---- reset mid-frame on ch1 (with overflow set) ----
    inhibit[1] = 1'b1;
    for (int i = 0; i < 9; i++) write_byte(1, 8'h40 + 8'(i));
    check_eq("ch1_ovf", overflow[1], 1);
    inhibit[1] = 1'b0;
    c = 0;
    while (busy[1] !== 1'b1 && c < 100) begin step(); c++; end
    for (int i = 0; i < 3; i++) wait_rise(1, c);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mrst_clk", ps2_clk[1], 1);
    check_eq("mrst_data", ps2_data[1], 1);
    check_eq("mrst_level", lvl(1), 0);
    check_eq("mrst_busy", busy[1], 0);
    check_eq("mrst_ovf", overflow[1], 0);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin step(); if (busy !== 2'b00) ok = 1'b0; end
    check_eq("mrst_no_frames", ok, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
